jtdd_mcu_bridge: RTL

// Main-CPU <-> MCU communication stage, between jtdd_main and the MCU core.

---
 rtl/jtdd_mcu_bridge.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/jtdd_mcu_bridge.sv
// jtdd_mcu_bridge
// Main-CPU <-> MCU communication stage. Owns the shared RAM, arbitrates it
// with a HALT/ACK handshake toward the MCU, stalls the main CPU while the
// MCU bus is being claimed, and carries the NMI/IRQ flags between sides.

module jtdd_mcu_bridge #(
    parameter int AW   = 9,
    parameter int HOLD = 4,
    parameter int TOUT = 255
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cpu_cen,
    input  logic          com_cs,
    input  logic          cpu_wrn,
    input  logic [AW-1:0] cpu_AB,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    shared_dout,
    output logic          cpu_wait,
    input  logic          nmi_set,
    input  logic          irq_clr,
    input  logic          mcu_rstb,
    output logic          mcu_halt,
    input  logic          mcu_hack,
    input  logic [AW-1:0] mcu_addr,
    input  logic          mcu_we,
    input  logic [7:0]    mcu_wdata,
    output logic [7:0]    mcu_rdata,
    output logic          mcu_nmi,
    input  logic          mcu_nmi_ack,
    input  logic          irq_set,
    output logic          mcu_irqmain,
    output logic          timeout
);

    localparam int HW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACCESS,
        ST_RELEASE
    } state_t;

    state_t          state;
    logic [7:0]      req_cnt;
    logic [HW-1:0]   hold_cnt;
    logic [AW-1:0]   lat_addr;
    logic [7:0]      lat_data;
    logic            lat_wrn;
    logic [7:0]      ram [0:(1<<AW)-1];

    logic            new_access;
    logic            main_we;
    logic            mcu_we_ok;

    assign new_access = com_cs & cpu_cen;
    assign main_we    = (state == ST_ACCESS) && !lat_wrn;
    // The main side owns the RAM during its write cycle; the MCU is also
    // locked out whenever it is halted or held in reset.
    assign mcu_we_ok  = mcu_we && mcu_rstb && !mcu_halt && !main_we;

    // Arbitration FSM: claims the MCU bus, performs one main access, then
    // keeps the bus for a short burst window before handing it back.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            req_cnt     <= '0;
            hold_cnt    <= '0;
            lat_addr    <= '0;
            lat_data    <= '0;
            lat_wrn     <= 1'b1;
            shared_dout <= '0;
            cpu_wait    <= 1'b0;
            mcu_halt    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (new_access) begin
                        lat_addr <= cpu_AB;
                        lat_data <= cpu_dout;
                        lat_wrn  <= cpu_wrn;
                        req_cnt  <= '0;
                        cpu_wait <= 1'b1;
                        if (mcu_rstb) begin
                            mcu_halt <= 1'b1;
                            state    <= ST_REQ;
                        end else begin
                            state    <= ST_ACCESS;
                        end
                    end
                end
                ST_REQ: begin
                    req_cnt <= req_cnt + 8'd1;
                    if (mcu_hack || !mcu_rstb) begin
                        state <= ST_ACCESS;
                    end else if (req_cnt == 8'(TOUT)) begin
                        state   <= ST_ACCESS;
                        timeout <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (lat_wrn) begin
                        shared_dout <= ram[lat_addr];
                    end
                    cpu_wait <= 1'b0;
                    hold_cnt <= HW'(HOLD);
                    state    <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (new_access) begin
                        lat_addr <= cpu_AB;
                        lat_data <= cpu_dout;
                        lat_wrn  <= cpu_wrn;
                        cpu_wait <= 1'b1;
                        state    <= ST_ACCESS;
                    end else if (hold_cnt <= HW'(1)) begin
                        hold_cnt <= '0;
                        mcu_halt <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Shared RAM storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (main_we) begin
            ram[lat_addr] <= lat_data;
        end else if (mcu_we_ok) begin
            ram[mcu_addr] <= mcu_wdata;
        end
    end

    // MCU read port, one clock of latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mcu_rdata <= '0;
        end else begin
            mcu_rdata <= ram[mcu_addr];
        end
    end

    // NMI and IRQ flags; a set always beats a same-cycle clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mcu_nmi     <= 1'b0;
            mcu_irqmain <= 1'b0;
        end else begin
            if (nmi_set && cpu_cen) begin
                mcu_nmi <= 1'b1;
            end else if (mcu_nmi_ack || !mcu_rstb) begin
                mcu_nmi <= 1'b0;
            end

            if (irq_set) begin
                mcu_irqmain <= 1'b1;
            end else if (irq_clr && cpu_cen) begin
                mcu_irqmain <= 1'b0;
            end
        end
    end

endmodule
